// File: rtl/shm_pkg.sv
// shm_pkg: shared constants and helpers for the setup/hold monitor.
//   - DEF_* : default parameter values for setuphold_monitor
//   - cnt_width() : bits needed to hold 0..max_val (never less than 1)
//   - sat_inc() : saturating increment on a 32-bit carrier; callers
//     cast to and from their own widths (counter widths up to 32 bits)
package shm_pkg;

  localparam int DEF_CH    = 4;
  localparam int DEF_SETUP = 3;
  localparam int DEF_HOLD  = 2;
  localparam int DEF_CNT_W = 8;

  // A zero-width counter is not legal, so HOLD=0 still gets one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/shm_channel.sv
// shm_channel: setup/hold checking for one data channel.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   ref_edge    : reference rising edge detected this cycle (from top)
//   data        : monitored data bit
//   cond        : check enable, latched at each reference edge
//                 (only honoured when SHM_COND_EN is defined)
//   clr         : synchronous clear of the violation counter
//   setup_viol  : one-cycle registered setup-violation pulse
//   hold_viol   : one-cycle registered hold-violation pulse
//   ntfr        : toggles on every violation
//   viol_cnt    : saturating violation count
//
// Optional feature macro: SHM_COND_EN (per-edge conditional checking).
module shm_channel
  import shm_pkg::*;
#(
  parameter int SETUP = DEF_SETUP,
  parameter int HOLD  = DEF_HOLD,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_edge,
  input  logic             data,
  input  logic             cond,
  input  logic             clr,
  output logic             setup_viol,
  output logic             hold_viol,
  output logic             ntfr,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int              SW      = cnt_width(SETUP);
  localparam int              HW      = cnt_width(HOLD);
  localparam logic [SW-1:0]   SETUP_V = SW'(SETUP);
  localparam logic [HW-1:0]   HOLD_V  = HW'(HOLD);
  localparam logic [31:0]     CNT_MAX = 32'({CNT_W{1'b1}});

  logic             data_q;
  logic [SW-1:0]    stab_q, stab_d;
  logic [HW-1:0]    win_q, win_d;   // remaining hold-window cycles; 0 = closed
  logic             cond_q, cond_d;
  logic             change;
  logic             check_en;
  logic             setup_d, hold_d, viol_d;
  logic [CNT_W-1:0] cnt_d;

`ifdef SHM_COND_EN
  assign check_en = cond;
`else
  logic unused_cond;
  assign check_en    = 1'b1;
  assign unused_cond = cond;
`endif

  always_comb begin
    change  = data ^ data_q;
    // stab_d counts stable cycles including the current one, so a change
    // in the edge cycle itself yields 0 and fails the setup check.
    stab_d  = change ? '0 : SW'(sat_inc(32'(stab_q), 32'(SETUP)));
    setup_d = ref_edge && check_en && (stab_d < SETUP_V);
    hold_d  = 1'b0;
    win_d   = win_q;
    cond_d  = cond_q;
    if (ref_edge) begin
      // A new edge always restarts (or closes) the window; a change in
      // this cycle belongs to the setup check of the new edge.
      cond_d = check_en;
      win_d  = check_en ? HOLD_V : '0;
    end else if (win_q != '0) begin
      if (change && cond_q) begin
        hold_d = 1'b1;
        win_d  = '0;
      end else begin
        win_d = win_q - HW'(1);
      end
    end
    viol_d = setup_d | hold_d;
    if (clr) begin
      cnt_d = '0;
    end else if (viol_d) begin
      cnt_d = CNT_W'(sat_inc(32'(viol_cnt), CNT_MAX));
    end else begin
      cnt_d = viol_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= data;
      stab_q     <= SETUP_V;
      win_q      <= '0;
      cond_q     <= 1'b0;
      setup_viol <= 1'b0;
      hold_viol  <= 1'b0;
      ntfr       <= 1'b0;
      viol_cnt   <= '0;
    end else begin
      data_q     <= data;
      stab_q     <= stab_d;
      win_q      <= win_d;
      cond_q     <= cond_d;
      setup_viol <= setup_d;
      hold_viol  <= hold_d;
      ntfr       <= ntfr ^ viol_d;
      viol_cnt   <= cnt_d;
    end
  end

endmodule

// File: rtl/setuphold_monitor.sv
// setuphold_monitor: multi-channel synthesizable setup/hold monitor.
// Detects rising edges of a reference strobe and checks every data
// channel for stability SETUP cycles before and HOLD cycles after it.
//
// Ports:
//   clk, rst     : sampling clock, synchronous active-high reset
//   ref_i        : reference strobe
//   data_i       : CH monitored data bits
//   cond_i       : CH per-channel check enables (SHM_COND_EN only)
//   clr_i        : synchronous clear of all violation counters
//   setup_viol_o : CH one-cycle setup-violation pulses
//   hold_viol_o  : CH one-cycle hold-violation pulses
//   ntfr_o       : CH notifiers, toggling per violation
//   viol_cnt_o   : CH saturating counters, channel c at [c*CNT_W +: CNT_W]
//
// Optional feature macro: SHM_COND_EN (per-edge conditional checking).
module setuphold_monitor
  import shm_pkg::*;
#(
  parameter int CH    = DEF_CH,
  parameter int SETUP = DEF_SETUP,
  parameter int HOLD  = DEF_HOLD,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ref_i,
  input  logic [CH-1:0]       data_i,
  input  logic [CH-1:0]       cond_i,
  input  logic                clr_i,
  output logic [CH-1:0]       setup_viol_o,
  output logic [CH-1:0]       hold_viol_o,
  output logic [CH-1:0]       ntfr_o,
  output logic [CH*CNT_W-1:0] viol_cnt_o
);

  logic ref_q;
  logic ref_edge;

  // Reset loads the live strobe so the first cycle out of reset never
  // reports a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= ref_i;
    end else begin
      ref_q <= ref_i;
    end
  end

  assign ref_edge = ref_i & ~ref_q;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    shm_channel #(
      .SETUP (SETUP),
      .HOLD  (HOLD),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .ref_edge   (ref_edge),
      .data       (data_i[c]),
      .cond       (cond_i[c]),
      .clr        (clr_i),
      .setup_viol (setup_viol_o[c]),
      .hold_viol  (hold_viol_o[c]),
      .ntfr       (ntfr_o[c]),
      .viol_cnt   (viol_cnt_o[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_setuphold_monitor.sv
// tb_setuphold_monitor: self-checking bench for setuphold_monitor.
// Reference model works on absolute cycle numbers (time since last
// change / last edge) rather than per-cycle counters.
module tb_setuphold_monitor;

  localparam int CH      = 4;
  localparam int SETUP   = 3;
  localparam int HOLD    = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int W       = 3 * CH + CH * CNT_W;
`ifdef SHM_COND_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst;
  logic                ref_i;
  logic [CH-1:0]       data_i;
  logic [CH-1:0]       cond_i;
  logic                clr_i;
  logic [CH-1:0]       setup_viol_o;
  logic [CH-1:0]       hold_viol_o;
  logic [CH-1:0]       ntfr_o;
  logic [CH*CNT_W-1:0] viol_cnt_o;
  logic [W-1:0]        obs;

  always #5 clk = ~clk;

  setuphold_monitor #(
    .CH (CH), .SETUP (SETUP), .HOLD (HOLD), .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ref_i        (ref_i),
    .data_i       (data_i),
    .cond_i       (cond_i),
    .clr_i        (clr_i),
    .setup_viol_o (setup_viol_o),
    .hold_viol_o  (hold_viol_o),
    .ntfr_o       (ntfr_o),
    .viol_cnt_o   (viol_cnt_o)
  );

  assign obs = {setup_viol_o, hold_viol_o, ntfr_o, viol_cnt_o};

  // ---------------- model / scoreboard state ----------------
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [CH-1:0] cur_d = '0;
  logic [CH-1:0] m_prev_data;
  logic          m_prev_ref;
  int            m_last_change [CH];
  int            m_last_edge   [CH];
  bit            m_armed       [CH];
  bit            m_used        [CH];
  int            m_cnt         [CH];
  logic [CH-1:0] m_ntfr;
  logic [W-1:0]  exp_q [$];

  // Driver: applies one cycle of inputs, predicts the registered outputs
  // that result and pushes them to exp_q, then advances past the edge.
  task automatic apply(input logic [CH-1:0] d, input logic r,
                       input logic [CH-1:0] c, input logic clr,
                       input logic rs);
    logic [CH-1:0] sv, hv;
    logic [W-1:0]  e;
    bit            ed, chg, en;
    data_i = d; ref_i = r; cond_i = c; clr_i = clr; rst = rs;
    sv = '0;
    hv = '0;
    if (rs) begin
      for (int k = 0; k < CH; k++) begin
        m_last_change[k] = -100;
        m_last_edge[k]   = -100;
        m_armed[k]       = 1'b0;
        m_used[k]        = 1'b0;
        m_cnt[k]         = 0;
      end
      m_ntfr = '0;
    end else begin
      ed = r && !m_prev_ref;
      for (int k = 0; k < CH; k++) begin
        chg = (d[k] !== m_prev_data[k]);
        if (chg) m_last_change[k] = cyc;
        en = COND_EN ? c[k] : 1'b1;
        if (ed && en && (cyc - m_last_change[k] < SETUP)) sv[k] = 1'b1;
        if (ed) begin
          m_armed[k]     = en;
          m_last_edge[k] = cyc;
          m_used[k]      = 1'b0;
        end else if (m_armed[k] && !m_used[k] && chg &&
                     (cyc - m_last_edge[k] <= HOLD)) begin
          hv[k]     = 1'b1;
          m_used[k] = 1'b1;
        end
        if (sv[k] || hv[k]) m_ntfr[k] = ~m_ntfr[k];
        if (clr) m_cnt[k] = 0;
        else if ((sv[k] || hv[k]) && m_cnt[k] < CNT_MAX) m_cnt[k]++;
      end
    end
    m_prev_data = d;
    m_prev_ref  = r;
    e = '0;
    e[W-1 -: CH]      = sv;
    e[W-CH-1 -: CH]   = hv;
    e[W-2*CH-1 -: CH] = m_ntfr;
    for (int k = 0; k < CH; k++) e[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    cur_d = 4'b1010;
    apply(cur_d, 1'b1, '1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (obs !== e || obs !== '0) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", obs, e);
    end
    // Out of reset with ref still high and data unchanged: nothing fires.
    for (int i = 0; i < 3; i++) begin
      apply(cur_d, (i == 0), '1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs !== e || obs !== '0) begin
        bad++;
        $display("FAIL reset_release step %0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_setup();
    logic [CH-1:0] tog [12];
    logic          rr  [12];
    logic [CH-1:0] sp  [12];
    logic [W-1:0]  e;
    tog = '{4'b0010, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0};
    rr  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    sp  = '{0, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      cur_d = cur_d ^ tog[i];
      apply(cur_d, rr[i], '1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL setup_model step %0d: got %h want %h", i, obs, e);
      end
      total++;
      if (setup_viol_o !== sp[i]) begin
        bad++;
        $display("FAIL setup_pulse step %0d: got %b want %b", i, setup_viol_o, sp[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [CH-1:0] tog [7];
    logic          rr  [7];
    logic [CH-1:0] hp  [7];
    logic [W-1:0]  e;
    tog = '{0, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0};
    rr  = '{1, 0, 0, 0, 0, 0, 0};
    hp  = '{0, 4'b0001, 0, 0, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      cur_d = cur_d ^ tog[i];
      apply(cur_d, rr[i], '1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL hold_model step %0d: got %h want %h", i, obs, e);
      end
      total++;
      if (hold_viol_o !== hp[i] || setup_viol_o !== '0) begin
        bad++;
        $display("FAIL hold_pulse step %0d: got %b/%b want %b/0000",
                 i, hold_viol_o, setup_viol_o, hp[i]);
      end
    end
  endtask

  task automatic test_reedge();
    logic [CH-1:0] tog [9];
    logic          rr  [9];
    logic [CH-1:0] sp  [9];
    logic [W-1:0]  e;
    tog = '{0, 0, 4'b0100, 0, 0, 4'b0100, 0, 0, 0};
    rr  = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    sp  = '{0, 0, 4'b0100, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      cur_d = cur_d ^ tog[i];
      apply(cur_d, rr[i], '1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reedge_model step %0d: got %h want %h", i, obs, e);
      end
      total++;
      if (setup_viol_o !== sp[i] || hold_viol_o !== '0) begin
        bad++;
        $display("FAIL reedge_pulse step %0d: got %b/%b want %b/0000",
                 i, setup_viol_o, hold_viol_o, sp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] e;
    for (int v = 0; v < 6; v++) begin
      cur_d = cur_d ^ 4'b1000;
      apply(cur_d, 1'b1, '1, (v == 5), 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL sat_model viol %0d: got %h want %h", v, obs, e);
      end
      if (v == 4) begin
        total++;
        if (viol_cnt_o[3*CNT_W +: CNT_W] !== CNT_W'(CNT_MAX)) begin
          bad++;
          $display("FAIL sat_count: got %0d want %0d",
                   viol_cnt_o[3*CNT_W +: CNT_W], CNT_MAX);
        end
      end
      if (v == 5) begin
        total++;
        if (viol_cnt_o !== '0 || setup_viol_o !== 4'b1000) begin
          bad++;
          $display("FAIL clr_priority: got cnt %h pulse %b want 0 / 1000",
                   viol_cnt_o, setup_viol_o);
        end
      end
      for (int i = 0; i < 3; i++) begin
        apply(cur_d, 1'b0, '1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL sat_idle viol %0d step %0d: got %h want %h", v, i, obs, e);
        end
      end
    end
  endtask

  task automatic test_cond();
    logic [W-1:0]  e;
    logic [CH-1:0] ce;
    logic [CH-1:0] sp, hp;
    for (int pass = 0; pass < 2; pass++) begin
      ce = (pass == 0) ? 4'b1110 : 4'b1111;
      sp = (pass == 1 || !COND_EN) ? 4'b0001 : 4'b0000;
      hp = sp;
      for (int i = 0; i < 6; i++) begin
        if (i == 1 || i == 2) cur_d = cur_d ^ 4'b0001;
        apply(cur_d, (i == 1), (i == 1) ? ce : 4'b1111, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL cond_model pass %0d step %0d: got %h want %h", pass, i, obs, e);
        end
        if (i == 1) begin
          total++;
          if (setup_viol_o !== sp) begin
            bad++;
            $display("FAIL cond_setup pass %0d: got %b want %b", pass, setup_viol_o, sp);
          end
        end
        if (i == 2) begin
          total++;
          if (hold_viol_o !== hp) begin
            bad++;
            $display("FAIL cond_hold pass %0d: got %b want %b", pass, hold_viol_o, hp);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 2) cur_d = cur_d ^ 4'b0001;
      apply(cur_d, (i == 0), '1, 1'b0, (i == 1));
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL rstmid_model step %0d: got %h want %h", i, obs, e);
      end
      if (i >= 1) begin
        total++;
        if (obs !== '0) begin
          bad++;
          $display("FAIL rstmid_quiet step %0d: got %h want 0", i, obs);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0]  e;
    logic [CH-1:0] tog;
    logic          r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tog = '0;
      for (int k = 0; k < CH; k++) tog[k] = ($urandom_range(0, 3) == 0);
      cur_d = cur_d ^ tog;
      if ($urandom_range(0, 2) == 0) r = ~r;
      apply(cur_d, r, CH'($urandom_range(0, (1 << CH) - 1)),
            ($urandom_range(0, 40) == 0), ($urandom_range(0, 150) == 0));
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL random cycle %0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst    = 1'b1;
    ref_i  = 1'b0;
    data_i = '0;
    cond_i = '1;
    clr_i  = 1'b0;
    test_reset();
    test_setup();
    test_hold();
    test_reedge();
    test_saturation();
    test_cond();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
